// File: rtl/ram_pkg.sv
// Shared types and the byte-merge helper for the dual-port RAM.
// Used by both the write path and the write-first read bypass.
package ram_pkg;

    typedef enum logic {RDW_READ_FIRST, RDW_WRITE_FIRST} rdw_mode_e;
    typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_e;

    // Widest word byte_merge handles; callers zero-extend and truncate.
    localparam int unsigned MERGE_W = 256;
    localparam int unsigned MERGE_B = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_w,
        input logic [MERGE_W-1:0] new_w,
        input logic [MERGE_B-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int unsigned i = 0; i < MERGE_B; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Data+valid delay line behind the RAM's stage-1 read register.
// Data stages only load when their valid is set, so the output holds between reads.
module ram_rd_pipe #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned RAM_RD_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    localparam int unsigned STAGES = RAM_RD_LATENCY - 1;

    logic [WIDTH-1:0] data_q  [STAGES];
    logic             valid_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                data_q[i]  <= '0;
                valid_q[i] <= 1'b0;
            end
        end else begin
            valid_q[0] <= valid_i;
            if (valid_i) begin
                data_q[0] <= data_i;
            end
            for (int unsigned i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign data_o  = data_q[STAGES-1];
    assign valid_o = valid_q[STAGES-1];

endmodule

// File: rtl/ram_dual_port.sv
// Simple-dual-port RAM with byte enables, registered read latency, selectable
// read-during-write behaviour and a clear engine that initialises the array.
module ram_dual_port
    import ram_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      DEPTH      = 4,
    parameter int unsigned      RD_LATENCY = 1,
    parameter rdw_mode_e        RDW_MODE   = RDW_READ_FIRST,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         din,
    input  logic [$clog2(DEPTH)-1:0] write_address,
    input  logic [WIDTH/8-1:0]       byte_en,
    input  logic                     write_en,
    input  logic [$clog2(DEPTH)-1:0] read_address,
    input  logic                     read_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     clear_req,
    output logic                     busy
);

    localparam int unsigned   AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    clr_state_e       state_q, state_d;
    logic [AW-1:0]    clr_addr_q, clr_addr_d;
    logic             busy_q;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    logic             idle, wr_in_range, rd_in_range, wr_hit;
    logic [WIDTH-1:0] wr_word, rd_word, wr_merged;

    // Clear FSM: sweep every address once, then hand the array back.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            CLR_RUN: begin
                clr_addr_d = clr_addr_q + AW'(1);
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = CLR_IDLE;
                    clr_addr_d = '0;
                end
            end
            CLR_IDLE: begin
                if (clear_req) begin
                    state_d    = CLR_RUN;
                    clr_addr_d = '0;
                end
            end
        endcase
    end

    // User write/read path; addresses beyond DEPTH are dropped or read as zero.
    always_comb begin
        idle        = (state_q == CLR_IDLE);
        wr_in_range = 32'(write_address) < DEPTH;
        rd_in_range = 32'(read_address) < DEPTH;
        wr_hit      = idle && write_en && wr_in_range;
        wr_word     = wr_in_range ? mem[write_address] : '0;
        rd_word     = rd_in_range ? mem[read_address] : '0;
        wr_merged   = WIDTH'(byte_merge(MERGE_W'(wr_word), MERGE_W'(din), MERGE_B'(byte_en)));
        rd_valid_d  = idle && read_en;
        rd_data_d   = rd_data_q;
        if (rd_valid_d) begin
            rd_data_d = rd_word;
            if (RDW_MODE == RDW_WRITE_FIRST && wr_hit && write_address == read_address) begin
                rd_data_d = wr_merged;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLR_RUN;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= (state_d == CLR_RUN);
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // The array has no reset; the clear engine owns initialisation.
    always_ff @(posedge clk) begin
        if (state_q == CLR_RUN) begin
            mem[clr_addr_q] <= INIT_VALUE;
        end else if (wr_hit) begin
            mem[write_address] <= wr_merged;
        end
    end

    if (RD_LATENCY > 1) begin : g_pipe
        ram_rd_pipe #(
            .WIDTH          (WIDTH),
            .RAM_RD_LATENCY (RD_LATENCY)
        ) u_rd_pipe (
            .clk     (clk),
            .rst_n   (rst_n),
            .data_i  (rd_data_q),
            .valid_i (rd_valid_q),
            .data_o  (dout),
            .valid_o (dout_valid)
        );
    end else begin : g_no_pipe
        assign dout       = rd_data_q;
        assign dout_valid = rd_valid_q;
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_ram_dual_port.sv
// Scoreboard bench for ram_dual_port: group A (DEPTH 8, latency 2, both RDW modes)
// and group B (DEPTH 5, latency 1 and 3).
`timescale 1ns/1ps
module tb_ram_dual_port;
    import ram_pkg::*;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    localparam logic [15:0] INIT = 16'h00A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_g [2];
    logic [15:0] din_g   [2];
    logic [2:0]  wa_g    [2];
    logic [2:0]  ra_g    [2];
    logic [1:0]  be_g    [2];
    logic        we_g    [2];
    logic        re_g    [2];
    logic        clr_g   [2];

    logic [15:0] dout [4];
    logic        dv   [4];
    logic        busy [4];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat [4] = '{2, 2, 1, 3};
    int          left [2];
    logic [15:0] mdl [2][8];
    logic [15:0] hold [4];
    exp_t        sb [4][$];

    always @(posedge clk) cyc <= cyc + 1;

    ram_dual_port #(.WIDTH(16), .DEPTH(8), .RD_LATENCY(2), .RDW_MODE(RDW_READ_FIRST), .INIT_VALUE(INIT)) u_rf (
        .clk(clk), .rst_n(rst_n_g[0]), .din(din_g[0]), .write_address(wa_g[0]), .byte_en(be_g[0]),
        .write_en(we_g[0]), .read_address(ra_g[0]), .read_en(re_g[0]), .dout(dout[0]),
        .dout_valid(dv[0]), .clear_req(clr_g[0]), .busy(busy[0]));
    ram_dual_port #(.WIDTH(16), .DEPTH(8), .RD_LATENCY(2), .RDW_MODE(RDW_WRITE_FIRST), .INIT_VALUE(INIT)) u_wf (
        .clk(clk), .rst_n(rst_n_g[0]), .din(din_g[0]), .write_address(wa_g[0]), .byte_en(be_g[0]),
        .write_en(we_g[0]), .read_address(ra_g[0]), .read_en(re_g[0]), .dout(dout[1]),
        .dout_valid(dv[1]), .clear_req(clr_g[0]), .busy(busy[1]));
    ram_dual_port #(.WIDTH(16), .DEPTH(5), .RD_LATENCY(1), .RDW_MODE(RDW_READ_FIRST), .INIT_VALUE(INIT)) u_l1 (
        .clk(clk), .rst_n(rst_n_g[1]), .din(din_g[1]), .write_address(wa_g[1]), .byte_en(be_g[1]),
        .write_en(we_g[1]), .read_address(ra_g[1]), .read_en(re_g[1]), .dout(dout[2]),
        .dout_valid(dv[2]), .clear_req(clr_g[1]), .busy(busy[2]));
    ram_dual_port #(.WIDTH(16), .DEPTH(5), .RD_LATENCY(3), .RDW_MODE(RDW_READ_FIRST), .INIT_VALUE(INIT)) u_l3 (
        .clk(clk), .rst_n(rst_n_g[1]), .din(din_g[1]), .write_address(wa_g[1]), .byte_en(be_g[1]),
        .write_en(we_g[1]), .read_address(ra_g[1]), .read_en(re_g[1]), .dout(dout[3]),
        .dout_valid(dv[3]), .clear_req(clr_g[1]), .busy(busy[3]));

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
        return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
    endfunction

    // Output monitor: pops the scoreboard on every dout_valid and checks hold otherwise.
    exp_t e;
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (dv[k] === 1'b1) begin
                checks++;
                if (sb[k].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid inst%0d: dout_valid=1 dout=%h at cycle %0d, required no valid", k, dout[k], cyc);
                end else begin
                    e = sb[k].pop_front();
                    if (dout[k] !== e.data || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL read_data inst%0d: got %h at cycle %0d, required %h at cycle %0d", k, dout[k], cyc, e.data, e.cyc);
                    end
                end
                hold[k] = dout[k];
            end else if (sb[k].size() > 0 && sb[k][0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_valid inst%0d: dout_valid=%b at cycle %0d, required 1 with %h", k, dv[k], cyc, sb[k][0].data);
                void'(sb[k].pop_front());
            end else begin
                checks++;
                if (dout[k] !== hold[k]) begin
                    errors++;
                    $display("FAIL dout_hold inst%0d: got %h, required %h", k, dout[k], hold[k]);
                end
            end
        end
    end

    // One cycle of stimulus on group g; also checks busy against the bench's clear model.
    task automatic step(input int g, input logic we, input logic [2:0] wa, input logic [15:0] d,
                        input logic [1:0] be, input logic re, input logic [2:0] ra, input logic clr);
        int dep;
        logic [15:0] v;
        dep = (g == 0) ? 8 : 5;
        @(negedge clk);
        for (int k = 2*g; k < 2*g + 2; k++) begin
            checks++;
            if (busy[k] !== (left[g] > 0)) begin
                errors++;
                $display("FAIL busy inst%0d: got %b at cycle %0d, required %b", k, busy[k], cyc, left[g] > 0);
            end
        end
        we_g[g] = we; wa_g[g] = wa; din_g[g] = d; be_g[g] = be;
        re_g[g] = re; ra_g[g] = ra; clr_g[g] = clr;
        if (left[g] > 0) begin
            left[g]--;
        end else begin
            if (re) begin
                for (int k = 2*g; k < 2*g + 2; k++) begin
                    v = (int'(ra) < dep) ? mdl[g][ra] : 16'h0000;
                    if (k == 1 && we && wa == ra && int'(ra) < dep) v = merge(v, d, be);
                    sb[k].push_back('{data: v, cyc: cyc + lat[k]});
                end
            end
            if (we && int'(wa) < dep) mdl[g][wa] = merge(mdl[g][wa], d, be);
            if (clr) begin
                left[g] = dep;
                for (int i = 0; i < 8; i++) mdl[g][i] = INIT;
            end
        end
    endtask

    task automatic idle_steps(input int g, input int n);
        for (int i = 0; i < n; i++) step(g, 1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic do_reset(input int g, input int hold_cycles);
        @(negedge clk);
        #1;
        rst_n_g[g] = 1'b0;
        we_g[g] = 1'b0; re_g[g] = 1'b0; clr_g[g] = 1'b0;
        for (int k = 2*g; k < 2*g + 2; k++) begin
            sb[k].delete();
            hold[k] = 16'h0000;
        end
        repeat (hold_cycles) @(negedge clk);
        for (int k = 2*g; k < 2*g + 2; k++) begin
            checks++;
            if (busy[k] !== 1'b1 || dv[k] !== 1'b0 || dout[k] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_state inst%0d: busy=%b dout_valid=%b dout=%h, required 1 0 0000", k, busy[k], dv[k], dout[k]);
            end
        end
        #1;
        rst_n_g[g] = 1'b1;
        left[g] = ((g == 0) ? 8 : 5) - 1;
        for (int i = 0; i < 8; i++) mdl[g][i] = INIT;
    endtask

    task automatic test_reset();
        do_reset(0, 3);
        idle_steps(0, 8);
    endtask

    task automatic test_init_readback();
        for (int a = 0; a < 8; a++) step(0, 1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(a), 1'b0);
        idle_steps(0, 4);
    endtask

    task automatic test_byte_en();
        step(0, 1'b1, 3'd3, 16'hBEEF, 2'b01, 1'b0, 3'd0, 1'b0);
        step(0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd3, 1'b0);
        step(0, 1'b1, 3'd3, 16'h1200, 2'b10, 1'b0, 3'd0, 1'b0);
        step(0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd3, 1'b0);
        step(0, 1'b1, 3'd3, 16'hFFFF, 2'b00, 1'b0, 3'd0, 1'b0);
        step(0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd3, 1'b0);
        idle_steps(0, 4);
    endtask

    task automatic test_rdw();
        step(0, 1'b1, 3'd5, 16'h1111, 2'b11, 1'b0, 3'd0, 1'b0);
        step(0, 1'b1, 3'd5, 16'h2222, 2'b11, 1'b1, 3'd5, 1'b0);
        step(0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd5, 1'b0);
        step(0, 1'b1, 3'd6, 16'hABCD, 2'b10, 1'b1, 3'd6, 1'b0);
        idle_steps(0, 4);
    endtask

    task automatic test_clear_inflight();
        step(0, 1'b1, 3'd2, 16'h3333, 2'b11, 1'b0, 3'd0, 1'b0);
        step(0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd2, 1'b1);
        for (int i = 0; i < 8; i++)
            step(0, 1'b1, 3'(i), 16'hDEAD, 2'b11, 1'b1, 3'd2, 1'b1);
        step(0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd2, 1'b0);
        step(0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd0, 1'b0);
        idle_steps(0, 4);
    endtask

    task automatic test_reset_mid();
        step(0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd1, 1'b1);
        idle_steps(0, 3);
        do_reset(0, 2);
        idle_steps(0, 8);
        step(0, 1'b1, 3'd1, 16'h7777, 2'b11, 1'b0, 3'd0, 1'b0);
        step(0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd1, 1'b0);
        do_reset(0, 1);
        idle_steps(0, 8);
        step(0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd1, 1'b0);
        idle_steps(0, 4);
    endtask

    task automatic test_back_to_back(input int g, input int n);
        for (int i = 0; i < n; i++)
            step(g, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0);
        idle_steps(g, 4);
    endtask

    task automatic test_sweep();
        do_reset(1, 2);
        idle_steps(1, 4);
        for (int a = 0; a < 5; a++) step(1, 1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(a), 1'b0);
        step(1, 1'b1, 3'd6, 16'hDEAD, 2'b11, 1'b0, 3'd0, 1'b0);
        step(1, 1'b1, 3'd7, 16'hBEEF, 2'b11, 1'b0, 3'd0, 1'b0);
        for (int a = 0; a < 8; a++) step(1, 1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(a), 1'b0);
        step(1, 1'b1, 3'd4, 16'h4444, 2'b11, 1'b1, 3'd4, 1'b0);
        step(1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd4, 1'b0);
        idle_steps(1, 4);
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst_n_g[g] = 1'b0; din_g[g] = '0; wa_g[g] = '0; ra_g[g] = '0;
            be_g[g] = '0; we_g[g] = 1'b0; re_g[g] = 1'b0; clr_g[g] = 1'b0;
            left[g] = 0;
        end
        for (int k = 0; k < 4; k++) hold[k] = 16'h0000;
        test_reset();
        test_init_readback();
        test_byte_en();
        test_rdw();
        test_clear_inflight();
        test_reset_mid();
        test_back_to_back(0, 40);
        test_sweep();
        test_back_to_back(1, 40);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (sb[k].size() != 0) begin
                errors++;
                $display("FAIL drain inst%0d: %0d reads outstanding, required 0", k, sb[k].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_dual_port.md
# ram_dual_port

Parametrised simple-dual-port RAM: one write port, one read port, one clock. Successor to the basic WIDTH/DEPTH RAM. Adds byte enables, a configurable registered read latency with a valid strobe, selectable read-during-write behaviour, and a hardware clear engine that initialises the array after reset or on request. It sits behind dataflow actors as their local buffer storage.

## Interface
Parameters:
- WIDTH, 8, data width in bits; must be a multiple of 8.
- DEPTH, 4, number of words; must be 2 or more; need not be a power of two.
- RD_LATENCY, 1, number of cycles from read_en to dout_valid; legal range 1..3.
- RDW_MODE, RDW_READ_FIRST, read-during-write behaviour (ram_pkg::rdw_mode_e).
- INIT_VALUE, '0, WIDTH-bit value written by the clear engine.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  WIDTH  write data.
- write_address  in  $clog2(DEPTH)  write word address.
- byte_en  in  WIDTH/8  per-byte write enable; bit i covers din[8i+7:8i].
- write_en  in  1  write strobe.
- read_address  in  $clog2(DEPTH)  read word address.
- read_en  in  1  read strobe.
- dout  out  WIDTH  read data.
- dout_valid  out  1  one-cycle pulse marking dout as the result of a read.
- clear_req  in  1  requests a clear of the whole array.
- busy  out  1  high while the clear engine owns the array.

## Operation
The clear FSM has two states.
- CLEAR: each cycle writes INIT_VALUE to mem[clr_addr], then increments clr_addr. On the cycle that writes DEPTH-1, the FSM moves to IDLE.
- IDLE: serves user traffic. clear_req=1 moves the FSM to CLEAR with clr_addr=0 on the next edge.

While in CLEAR:
- write_en, read_en and clear_req are ignored.
- No new dout_valid is produced.
- busy is registered and equals (state==CLEAR).

Writes (IDLE only):
- A write with write_en=1 updates only the bytes whose byte_en bit is 1.
- byte_en=0 with write_en=1 is a no-op.
- A write_address >= DEPTH is dropped.

Reads (IDLE only):
- read_en=1 samples mem[read_address] into pipeline stage 1.
- Stages 2..RD_LATENCY are plain delay stages.
- A read_address >= DEPTH returns 0, with dout_valid still asserted.

Read-during-write (same address, same cycle):
- RDW_READ_FIRST returns the old word.
- RDW_WRITE_FIRST returns the old word with the enabled bytes replaced by din.

dout holds its last value when dout_valid=0.

Reads already in flight when a clear starts complete normally with their pre-clear data.

## Timing
- Reset values: state=CLEAR, clr_addr=0, busy=1, dout=0, dout_valid=0, all pipeline valid bits 0.
- After rst_n rises, busy stays 1 for exactly DEPTH rising edges. The first user operation is accepted on the edge after busy falls.
- A clear_req sampled at edge t makes busy=1 after t. It stays 1 for DEPTH edges.
- Read sampled at edge t: dout and dout_valid are updated at edge t+RD_LATENCY-1, i.e. visible during cycle t+RD_LATENCY. Throughput is one read per cycle.
- A write sampled at edge t is visible to a read sampled at edge t+1 in either mode.
- rst_n asserted mid-clear or mid-read: the pipeline is flushed (no dout_valid) and the clear restarts from address 0.
- The array itself is not reset; only the clear engine initialises it.

## Structure
- Package ram_pkg holds:
  - typedef enum rdw_mode_e {RDW_READ_FIRST, RDW_WRITE_FIRST};
  - typedef enum clr_state_e {CLR_IDLE, CLR_RUN};
  - a function byte_merge(old, new, be) used by both the write path and the write-first bypass.
- One sub-module, ram_rd_pipe: a parametrised data+valid delay line of RAM_RD_LATENCY-1 stages with asynchronous active-low reset.
- The top level contains the array, the write/merge logic, the stage-1 read register with bypass, and the clear FSM.

## Test plan
All scenarios use WIDTH=16, DEPTH=8, RD_LATENCY=2, INIT_VALUE=16'h00A5.
- Release rst_n → busy=1 for exactly 8 edges. Then read address 0..7 back-to-back → 8 consecutive dout_valid pulses, each dout=16'h00A5, first pulse 2 cycles after the first read.
- Write 16'hBEEF to address 3 with byte_en=2'b01, then read address 3 → 16'h00EF. Write 16'h1200 with byte_en=2'b10, then read → 16'h12EF.
- Address 5 holds 16'h1111; write 16'h2222 and read address 5 in the same cycle → RDW_READ_FIRST returns 16'h1111, RDW_WRITE_FIRST returns 16'h2222. A read on the next cycle returns 16'h2222 in both modes.
- In IDLE with address 2 = 16'h3333:
  - issue read of address 2 and clear_req in the same cycle → that read still returns 16'h3333 with dout_valid;
  - busy is high for 8 edges;
  - writes and reads issued while busy produce no effect and no dout_valid;
  - afterwards address 2 reads 16'h00A5.
- Assert rst_n low during clear edge 4 and during an in-flight read → no dout_valid emitted. After release, busy again lasts 8 full edges.
- Parameter sweep with RD_LATENCY=1 and 3, DEPTH=5: latency matches the parameter. Writing address 6 changes nothing. Reading address 6 returns 0 with dout_valid.
